efuse_sequencer: RTL and testbench
==================================

# efuse_sequencer

Bit-level timing sequencer for the 32-bit eFuse macro. It sits between the eFuse main state machine and the fuse macro pins. It turns level-held `read`/`write` requests into per-bit address/strobe sequences with parameterised setup, pulse and hold widths. It returns the 32-bit read word, or a program-complete pulse, through a single-cycle `rd_done`/`wr_done` handshake.

## Interface
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named `clk` and `rst`.
- `T_SU`, default 2: setup and hold cycles around each strobe. Must be ≥1.
- `T_RD`, default 4: strobe-high cycles per read bit. Must be ≥1.
- `T_PGM`, default 100: strobe-high cycles per programmed bit. Must be ≥1 and ≤65535, because the timer is 16 bits.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `read`  in  1  read request, level-held until `rd_done`
- `write`  in  1  program request, level-held until `wr_done`
- `data_write`  in  32  word to program; 1 = blow bit
- `rd_done`  out  1  one-cycle pulse, `data_read` valid
- `wr_done`  out  1  one-cycle pulse, programming finished
- `data_read`  out  32  last word read from the macro
- `busy`  out  1  high whenever state ≠ IDLE
- `pgm_err`  out  1  verify mismatch flag (see Configuration)
- `fuse_csb`  out  1  macro chip select, active-low
- `fuse_pgenb`  out  1  program enable, active-low
- `fuse_load`  out  1  read/load enable, high in read pass
- `fuse_strobe`  out  1  bit strobe
- `fuse_addr`  out  5  bit address
- `fuse_q`  in  1  macro read data for the addressed bit

## Operation
- States: IDLE, START, NEXT, SETUP, PULSE, HOLD, DONE.
- **IDLE**
  - Samples requests; `write` has priority over `read` when both are high.
  - On accept: latch `data_write` into an internal register, clear the bit index, set the mode, go to START.
  - Requests are ignored while `busy`.
- **START** (1 cycle)
  - `fuse_csb`=0.
  - Read mode: `fuse_load`=1, `fuse_pgenb`=1.
  - Program mode: `fuse_load`=0, `fuse_pgenb`=0.
  - Go to NEXT.
- **NEXT** (1 cycle per bit): drive `fuse_addr`=index.
  - Read mode, or program mode with the latched bit = 1: go to SETUP.
  - Program mode with the latched bit = 0: skip the bit.
  - After processing bit 31, go to DONE.
  - The index wraps 31→0 only through DONE/IDLE and never re-enters NEXT.
- **SETUP** (T_SU cycles): `fuse_strobe`=0.
- **PULSE** (T_RD or T_PGM cycles): `fuse_strobe`=1.
  - In read mode, `fuse_q` is captured into `data_read[index]` at the edge ending the last PULSE cycle.
- **HOLD** (T_SU cycles): `fuse_strobe`=0, then increment the index and go to NEXT.
- **DONE** (1 cycle)
  - Assert `rd_done` or `wr_done` for the active mode.
  - `fuse_csb`=1, `fuse_pgenb`=1, `fuse_load`=0.
  - Go to IDLE.
  - The requester drops its level one cycle later, so IDLE sees it low and no re-trigger occurs.
- `data_read` changes only during a read pass (bit-by-bit) and holds otherwise. A program pass never alters it.
- Reset mid-operation: the next edge forces IDLE and reset values. The strobe drops within one cycle, and no done pulse is issued.

## Timing
- Reset values:
  - `fuse_csb`=1, `fuse_pgenb`=1
  - `fuse_load`=0, `fuse_strobe`=0, `fuse_addr`=0
  - `data_read`=0, `rd_done`=0, `wr_done`=0, `busy`=0, `pgm_err`=0
- All outputs are registered.
- Read latency, from the accepting edge to `rd_done` high: 1 + 32·(2·T_SU + T_RD + 1) cycles. The default is 289.
- Program latency: 1 + 32 + n·(2·T_SU + T_PGM) cycles, where n = popcount(`data_write`).
  - Default n=1 gives 137.
  - n=0 gives 33.
- Address, `fuse_pgenb` and `fuse_load` are stable for at least T_SU cycles before strobe rise and after strobe fall.

## Configuration
- Macro `EFUSE_SEQ_VERIFY_EN`.
- When defined:
  - After the last program bit, the sequencer passes through START in read mode and performs a full read pass, updating `data_read`.
  - `pgm_err` is set to 1 if (`data_read` & latched `data_write`) ≠ latched `data_write`; otherwise it is cleared.
  - `wr_done` fires only after the verify pass. Program latency grows by 1 + 32·(2·T_SU + T_RD + 1).
- When undefined: no verify pass, and `pgm_err` is tied to 0.

## Test plan
- Read, macro model holding 0xA5A5_0F0F, `read` held → `rd_done` pulses once at cycle 289, `data_read`=0xA5A5_0F0F, 32 strobes each 4 cycles wide.
- Write `data_write`=0x0000_0001 → one 100-cycle strobe at `fuse_addr`=0 with `fuse_pgenb`=0, `wr_done` at cycle 137 (verify off).
- Write 0x0000_0000 → no strobe, `wr_done` at cycle 33, `data_read` unchanged.
- `read` and `write` both rise in the same cycle → program pass runs first, then read pass after `wr_done`; strobe-width checks enforce T_SU setup/hold on every bit.
- `rst` asserted mid-PULSE during programming → strobe low, `fuse_csb`=1, `busy`=0 one cycle later, no `wr_done`.
- With `EFUSE_SEQ_VERIFY_EN`: model ignores the program of bit 3 while writing 0x0000_0009 → `pgm_err`=1, `data_read`=0x0000_0001.

Source files
------------

// File: rtl/efuse_sequencer.sv
// efuse_sequencer: bit-level timing sequencer for the 32-bit eFuse macro.
// Converts level-held read/write requests into per-bit address and strobe
// sequences with setup, pulse and hold widths. Completion is a one-cycle
// rd_done or wr_done pulse.
// Optional build macro: EFUSE_SEQ_VERIFY_EN adds a read-back verify pass
// after programming and drives pgm_err. Without it, pgm_err is tied low.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a request; write wins over read
// S_START | macro selected, load/pgenb set for the pass mode
// S_NEXT  | address = index; decide whether this bit needs a strobe
// S_SETUP | T_SU cycles, strobe low, address stable
// S_PULSE | strobe high for T_RD (read) or T_PGM (program) cycles
// S_HOLD  | T_SU cycles, strobe low, then advance to the next bit
// S_DONE  | one-cycle completion pulse, macro deselected
module efuse_sequencer #(
    parameter int T_SU  = 2,
    parameter int T_RD  = 4,
    parameter int T_PGM = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] data_write,
    output logic        rd_done,
    output logic        wr_done,
    output logic [31:0] data_read,
    output logic        busy,
    output logic        pgm_err,
    output logic        fuse_csb,
    output logic        fuse_pgenb,
    output logic        fuse_load,
    output logic        fuse_strobe,
    output logic [4:0]  fuse_addr,
    input  logic        fuse_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_NEXT,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_DONE
    } state_t;

    // Timer reload values: the down-counter runs from N-1 to zero, so a
    // phase lasts exactly N cycles.
    localparam logic [15:0] C_SU  = 16'(T_SU - 1);
    localparam logic [15:0] C_RD  = 16'(T_RD - 1);
    localparam logic [15:0] C_PGM = 16'(T_PGM - 1);

    state_t      r_state;
    logic [4:0]  r_idx;
    logic [15:0] r_timer;
    logic [31:0] r_wdata;
    logic        r_pgm;
    logic        r_csb;
    logic        r_pgenb;
    logic        r_load;
    logic        r_strobe;
    logic        r_rd_done;
    logic        r_wr_done;
    logic        r_busy;
    logic [31:0] r_data_read;
`ifdef EFUSE_SEQ_VERIFY_EN
    logic        r_verify;
    logic        r_pgm_err;
`endif

    logic        w_bit_sel;
    logic        w_last_bit;
    logic        w_tc;
    logic        w_pass_end;

    // A read pass strobes every bit; a program pass only strobes bits to blow.
    assign w_bit_sel  = r_pgm ? r_wdata[r_idx] : 1'b1;
    assign w_last_bit = (r_idx == 5'd31);
    assign w_tc       = (r_timer == 16'd0);
    // Pass ends either on a skipped bit 31 or at the end of bit 31's hold.
    assign w_pass_end = ((r_state == S_NEXT) && !w_bit_sel && w_last_bit) ||
                        ((r_state == S_HOLD) && w_tc && w_last_bit);

    // Sequencer FSM with all macro-facing and handshake outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= 5'd0;
            r_timer     <= 16'd0;
            r_wdata     <= 32'd0;
            r_pgm       <= 1'b0;
            r_csb       <= 1'b1;
            r_pgenb     <= 1'b1;
            r_load      <= 1'b0;
            r_strobe    <= 1'b0;
            r_rd_done   <= 1'b0;
            r_wr_done   <= 1'b0;
            r_busy      <= 1'b0;
            r_data_read <= 32'd0;
`ifdef EFUSE_SEQ_VERIFY_EN
            r_verify    <= 1'b0;
            r_pgm_err   <= 1'b0;
`endif
        end else begin
            r_rd_done <= 1'b0;
            r_wr_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (write || read) begin
                        r_state <= S_START;
                        r_idx   <= 5'd0;
                        r_wdata <= data_write;
                        r_pgm   <= write;
                        r_busy  <= 1'b1;
                        r_csb   <= 1'b0;
                        r_load  <= ~write;
                        r_pgenb <= ~write;
`ifdef EFUSE_SEQ_VERIFY_EN
                        r_verify <= 1'b0;
`endif
                    end
                end
                S_START: begin
                    r_state <= S_NEXT;
                end
                S_NEXT: begin
                    if (w_bit_sel) begin
                        r_state <= S_SETUP;
                        r_timer <= C_SU;
                    end else if (!w_last_bit) begin
                        r_idx <= r_idx + 5'd1;
                    end
                end
                S_SETUP: begin
                    if (w_tc) begin
                        r_state  <= S_PULSE;
                        r_timer  <= r_pgm ? C_PGM : C_RD;
                        r_strobe <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                S_PULSE: begin
                    if (w_tc) begin
                        if (!r_pgm) begin
                            r_data_read[r_idx] <= fuse_q;
                        end
                        r_strobe <= 1'b0;
                        r_state  <= S_HOLD;
                        r_timer  <= C_SU;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                S_HOLD: begin
                    if (w_tc) begin
                        if (!w_last_bit) begin
                            r_idx   <= r_idx + 5'd1;
                            r_state <= S_NEXT;
                        end
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // End-of-pass handling overrides the per-state assignments above.
            if (w_pass_end) begin
`ifdef EFUSE_SEQ_VERIFY_EN
                if (r_pgm) begin
                    // Re-enter START in read mode for the verify pass.
                    r_pgm    <= 1'b0;
                    r_verify <= 1'b1;
                    r_idx    <= 5'd0;
                    r_state  <= S_START;
                    r_load   <= 1'b1;
                    r_pgenb  <= 1'b1;
                end else begin
                    r_state   <= S_DONE;
                    r_idx     <= 5'd0;
                    r_csb     <= 1'b1;
                    r_pgenb   <= 1'b1;
                    r_load    <= 1'b0;
                    r_wr_done <= r_verify;
                    r_rd_done <= ~r_verify;
                    if (r_verify) begin
                        r_pgm_err <= ((r_data_read & r_wdata) != r_wdata);
                    end
                end
`else
                r_state   <= S_DONE;
                r_idx     <= 5'd0;
                r_csb     <= 1'b1;
                r_pgenb   <= 1'b1;
                r_load    <= 1'b0;
                r_wr_done <= r_pgm;
                r_rd_done <= ~r_pgm;
`endif
            end
        end
    end

    assign rd_done     = r_rd_done;
    assign wr_done     = r_wr_done;
    assign data_read   = r_data_read;
    assign busy        = r_busy;
    assign fuse_csb    = r_csb;
    assign fuse_pgenb  = r_pgenb;
    assign fuse_load   = r_load;
    assign fuse_strobe = r_strobe;
    assign fuse_addr   = r_idx;
`ifdef EFUSE_SEQ_VERIFY_EN
    assign pgm_err     = r_pgm_err;
`else
    assign pgm_err     = 1'b0;
`endif

endmodule

// File: tb/tb_efuse_sequencer.sv
// Self-checking bench for efuse_sequencer: behavioural fuse macro model,
// expectation scoreboard popped on each done pulse, and a per-strobe
// width/setup/hold monitor. The verify scenario runs when
// EFUSE_SEQ_VERIFY_EN is defined.
module tb_efuse_sequencer;

    localparam int T_SU  = 2;
    localparam int T_RD  = 4;
    localparam int T_PGM = 100;
    localparam int RD_LAT = 1 + 32 * (2 * T_SU + T_RD + 1);

    logic        clk = 1'b0;
    logic        rst;
    logic        read;
    logic        write;
    logic [31:0] data_write;
    logic        rd_done;
    logic        wr_done;
    logic [31:0] data_read;
    logic        busy;
    logic        pgm_err;
    logic        fuse_csb;
    logic        fuse_pgenb;
    logic        fuse_load;
    logic        fuse_strobe;
    logic [4:0]  fuse_addr;
    logic        fuse_q;

    efuse_sequencer #(.T_SU(T_SU), .T_RD(T_RD), .T_PGM(T_PGM)) dut (
        .clk        (clk),
        .rst        (rst),
        .read       (read),
        .write      (write),
        .data_write (data_write),
        .rd_done    (rd_done),
        .wr_done    (wr_done),
        .data_read  (data_read),
        .busy       (busy),
        .pgm_err    (pgm_err),
        .fuse_csb   (fuse_csb),
        .fuse_pgenb (fuse_pgenb),
        .fuse_load  (fuse_load),
        .fuse_strobe(fuse_strobe),
        .fuse_addr  (fuse_addr),
        .fuse_q     (fuse_q)
    );

    always #5 clk = ~clk;

    // Fuse macro model: a bit blows only after a full T_PGM-cycle strobe.
    logic [31:0] mem = 32'd0;
    logic [31:0] ld_val = 32'd0;
    logic        ld_req = 1'b0;
    logic [31:0] ign = 32'd0;
    int          pcnt = 0;

    assign fuse_q = (!fuse_csb && fuse_load) ? mem[fuse_addr] : 1'b0;

    always @(posedge clk) begin
        if (ld_req) begin
            mem = ld_val;
            pcnt = 0;
        end else if (!fuse_csb && !fuse_pgenb && fuse_strobe) begin
            pcnt = pcnt + 1;
        end else begin
            if (pcnt >= T_PGM && !ign[fuse_addr]) mem[fuse_addr] = 1'b1;
            pcnt = 0;
        end
    end

    typedef struct {
        bit          wr;
        logic [31:0] dr;
        int          lat;
        int          ns;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_fuse = 32'd0;
    logic [31:0] exp_dr = 32'd0;
    logic        exp_err = 1'b0;
    logic [31:0] cur_wd = 32'd0;

    // Monitor state
    int   ncyc = 0;
    int   last_chg = 0;
    int   rise_cyc = 0;
    int   fall_cyc = 0;
    int   start_cyc = 0;
    int   nstrobe = 0;
    bit   pend_hold = 0;
    logic rise_pg = 1'b1;
    logic p_strobe = 1'b0;
    logic p_busy = 1'b0;
    logic p_done = 1'b0;
    logic [4:0] p_addr = 5'd0;
    logic p_pgenb = 1'b1;
    logic p_load = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of simulation, sampled on the falling edge, with all monitoring.
    task automatic tick();
        exp_t e;
        bit   chg;
        @(negedge clk);
        ncyc++;
        if (rst) begin
            pend_hold = 0;
        end else begin
            chg = (fuse_addr !== p_addr) || (fuse_pgenb !== p_pgenb) || (fuse_load !== p_load);
            if (chg) begin
                last_chg = ncyc;
                if (pend_hold) begin
                    chk("hold_time", 32'((ncyc - fall_cyc) >= T_SU), 32'd1);
                    pend_hold = 0;
                end
            end
            if (fuse_strobe && !p_strobe) begin
                rise_cyc = ncyc;
                rise_pg = fuse_pgenb;
                nstrobe++;
                chk("setup_time", 32'((ncyc - last_chg) >= T_SU), 32'd1);
                if (!fuse_pgenb) chk("pgm_bit_sel", 32'(cur_wd[fuse_addr]), 32'd1);
            end
            if (!fuse_strobe && p_strobe) begin
                chk("strobe_width", 32'(ncyc - rise_cyc), 32'(rise_pg ? T_RD : T_PGM));
                fall_cyc = ncyc;
                pend_hold = 1;
            end
            if (busy && !p_busy) begin
                start_cyc = ncyc;
                nstrobe = 0;
            end
            if (p_done) chk("done_one_cycle", 32'(rd_done | wr_done), 32'd0);
            if (rd_done || wr_done) begin
                chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("done_kind", 32'({wr_done, rd_done}), 32'({e.wr, ~e.wr}));
                    chk("data_read", data_read, e.dr);
                    chk("latency", 32'(ncyc - start_cyc), 32'(e.lat));
                    chk("strobe_count", 32'(nstrobe), 32'(e.ns));
                    chk("pgm_err", 32'(pgm_err), 32'(e.err));
                end
            end
        end
        p_strobe = fuse_strobe;
        p_busy = busy;
        p_done = rd_done | wr_done;
        p_addr = fuse_addr;
        p_pgenb = fuse_pgenb;
        p_load = fuse_load;
    endtask

    task automatic preload(input logic [31:0] v);
        ld_val = v;
        ld_req = 1'b1;
        tick();
        ld_req = 1'b0;
        exp_fuse = v;
    endtask

    // Pushes expectations, raises the request levels, drops each on its done.
    task automatic run(input bit do_wr, input bit do_rd, input logic [31:0] wd);
        exp_t e;
        int   target;
        int   seen;
        target = 0;
        seen = 0;
        if (do_wr) begin
            e.wr  = 1'b1;
            e.lat = 1 + 32 + $countones(wd) * (2 * T_SU + T_PGM);
            e.ns  = $countones(wd);
            exp_fuse = exp_fuse | (wd & ~ign);
`ifdef EFUSE_SEQ_VERIFY_EN
            e.lat = e.lat + RD_LAT;
            e.ns  = e.ns + 32;
            exp_dr = exp_fuse;
            exp_err = ((exp_fuse & wd) != wd);
`endif
            e.dr  = exp_dr;
            e.err = exp_err;
            sb.push_back(e);
            target++;
        end
        if (do_rd) begin
            e.wr  = 1'b0;
            e.lat = RD_LAT;
            e.ns  = 32;
            exp_dr = exp_fuse;
            e.dr  = exp_dr;
            e.err = exp_err;
            sb.push_back(e);
            target++;
        end
        if (do_wr) cur_wd = wd;
        write = do_wr;
        read = do_rd;
        data_write = wd;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (wr_done) begin
                write = 1'b0;
                seen++;
            end
            if (rd_done) begin
                read = 1'b0;
                seen++;
            end
            if (seen == target) break;
        end
        chk("request_completed", 32'(seen), 32'(target));
        write = 1'b0;
        read = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1;
        read = 1'b0;
        write = 1'b0;
        data_write = 32'd0;
        repeat (3) tick();
        chk("rst_csb", 32'(fuse_csb), 32'd1);
        chk("rst_pgenb", 32'(fuse_pgenb), 32'd1);
        chk("rst_load", 32'(fuse_load), 32'd0);
        chk("rst_strobe", 32'(fuse_strobe), 32'd0);
        chk("rst_addr", 32'(fuse_addr), 32'd0);
        chk("rst_data_read", data_read, 32'd0);
        chk("rst_dones", 32'({rd_done, wr_done}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pgm_err", 32'(pgm_err), 32'd0);
        rst = 1'b0;
        preload(32'hA5A5_0F0F);
        tick();

        run(1'b0, 1'b1, 32'h0);            // plain read
        run(1'b1, 1'b0, 32'h0000_0001);    // single bit program
        run(1'b1, 1'b0, 32'h0000_0000);    // nothing to blow
        run(1'b1, 1'b1, 32'h8000_0010);    // simultaneous: write first, then read

        // Reset in the middle of a programming pulse.
        cur_wd = 32'h0000_0100;
        data_write = 32'h0000_0100;
        write = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (fuse_strobe) break;
        end
        chk("mid_rst_strobe_seen", 32'(fuse_strobe), 32'd1);
        repeat (10) tick();
        rst = 1'b1;
        write = 1'b0;
        tick();
        chk("mid_rst_strobe", 32'(fuse_strobe), 32'd0);
        chk("mid_rst_csb", 32'(fuse_csb), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_wr_done", 32'(wr_done), 32'd0);
        tick();
        rst = 1'b0;
        exp_dr = 32'd0;
        exp_err = 1'b0;
        repeat (20) tick();
        chk("mid_rst_idle", 32'(busy), 32'd0);

        run(1'b0, 1'b1, 32'h0);            // read recovers after reset

`ifdef EFUSE_SEQ_VERIFY_EN
        preload(32'h0000_0000);
        ign = 32'h0000_0008;
        run(1'b1, 1'b0, 32'h0000_0009);    // bit 3 refuses to blow
        chk("verify_err_flag", 32'(pgm_err), 32'd1);
        chk("verify_data_read", data_read, 32'h0000_0001);
        ign = 32'h0;
        run(1'b1, 1'b0, 32'h0000_0002);    // clean program clears the flag
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
